dbg_mem_arbiter: RTL

Two-master arbiter that shares the single SoC data-memory port between the core load/store unit (master 0) and the JTAG debug module's memory path (master 1: dm_mem_we/addr/wdata/op_req). It sits between `jtag_top`'s memory outputs, the core, and the RAM. It issues one address phase per cycle to a fixed 1-cycle-latency synchronous memory and tracks which master owns the pending data phase so read data returns to the right requester. Debug has priority; an optional starvation guard bounds core wait time.

---
 rtl/dbg_mem_arbiter_if.sv | 49 ++++
 rtl/dbg_mem_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/dbg_mem_arbiter_if.sv
// Bus bundle for dbg_mem_arbiter: two requester ports (core LSU, debug module) plus the memory port.
// No storage; it only groups signals. Each requester holds its req and fields stable until it is granted.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and memory.
interface dbg_mem_arbiter_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    // master 0: core load/store unit
    logic                 m0_req_i;
    logic                 m0_we_i;
    logic [ADDR_BITS-1:0] m0_addr_i;
    logic [DATA_BITS-1:0] m0_wdata_i;
    logic                 m0_gnt_o;
    logic                 m0_rvalid_o;
    logic [DATA_BITS-1:0] m0_rdata_o;
    logic                 m0_hold_o;
    // master 1: JTAG debug module memory path
    logic                 m1_req_i;
    logic                 m1_we_i;
    logic [ADDR_BITS-1:0] m1_addr_i;
    logic [DATA_BITS-1:0] m1_wdata_i;
    logic                 m1_gnt_o;
    logic                 m1_rvalid_o;
    logic [DATA_BITS-1:0] m1_rdata_o;
    // shared 1-cycle-latency synchronous memory
    logic                 s_req_o;
    logic                 s_we_o;
    logic [ADDR_BITS-1:0] s_addr_o;
    logic [DATA_BITS-1:0] s_wdata_o;
    logic [DATA_BITS-1:0] s_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_hold_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output s_req_o, s_we_o, s_addr_o, s_wdata_o,
        input  s_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_hold_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
        output s_rdata_i
    );
endinterface

// File: rtl/dbg_mem_arbiter.sv
// Two-master arbiter for the data-memory port: debug (m1) wins over core (m0), and the memory answers one cycle later.
// Grant is combinational (0 cycles). Data phase is 1 cycle after grant. Throughput is one transfer per cycle.
// A losing requester is held. DBG_ARB_ANTI_STARVE_EN grants m0 once it has been denied MAX_WAIT cycles in a row.
module dbg_mem_arbiter #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int MAX_WAIT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dbg_mem_arbiter_if.slave   bus
);

    // State is the owner of the address phase issued in the previous cycle.
    // The encoding makes each rvalid a plain flop bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_M0   = 2'b01,
        S_M1   = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   m0_gnt, m1_gnt;
    logic   guard;

`ifdef DBG_ARB_ANTI_STARVE_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;

    // m0 has been denied long enough and is still asking
    assign guard = bus.m0_req_i && (wait_cnt_q == MAX_WAIT_C);

    // Count consecutive denied m0 cycles, saturating; any grant or dropped request restarts it
    always_comb begin
        wait_cnt_d = 4'd0;
        if (bus.m0_req_i && !m0_gnt) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign guard = 1'b0;
`endif

    // Priority decision; nothing is granted while reset is asserted
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (bus.m1_req_i && !guard) begin
                m1_gnt = 1'b1;
            end else if (bus.m0_req_i) begin
                m0_gnt = 1'b1;
            end
        end
    end

    // Remember who owns the data phase arriving next cycle
    always_comb begin
        state_d = S_IDLE;
        if (m1_gnt) begin
            state_d = S_M1;
        end else if (m0_gnt) begin
            state_d = S_M0;
        end
    end

    // Data-phase FSM; reset discards any pending data phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.m0_gnt_o  = m0_gnt;
    assign bus.m1_gnt_o  = m1_gnt;
    assign bus.m0_hold_o = rst_n & bus.m0_req_i & ~m0_gnt;

    // The memory port carries the granted master's fields and is all-zero when idle
    assign bus.s_req_o   = m0_gnt | m1_gnt;
    assign bus.s_we_o    = m1_gnt ? bus.m1_we_i    : (m0_gnt ? bus.m0_we_i    : 1'b0);
    assign bus.s_addr_o  = m1_gnt ? bus.m1_addr_i  : (m0_gnt ? bus.m0_addr_i  : '0);
    assign bus.s_wdata_o = m1_gnt ? bus.m1_wdata_i : (m0_gnt ? bus.m0_wdata_i : '0);

    // Read data is broadcast; only the owner's rvalid qualifies it (writes get rvalid as completion)
    assign bus.m0_rvalid_o = (state_q == S_M0);
    assign bus.m1_rvalid_o = (state_q == S_M1);
    assign bus.m0_rdata_o  = bus.s_rdata_i;
    assign bus.m1_rdata_o  = bus.s_rdata_i;

endmodule
